// File: rtl/bpm_period_calc.sv
// Trigger-period calculator: NUMERATOR / (bpm * subdivision) via a
// restoring divider that produces one quotient bit per clock.
module bpm_period_calc #(
  parameter int NUM_W = 40,
  parameter int DEN_W = 34,
  parameter int OUT_W = 34,
  parameter logic [NUM_W-1:0] NUMERATOR = 40'd12000000000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [DEN_W-1:0] i_bpm_counter,
  input  logic [1:0]       i_subdiv,
  output logic             o_busy,
  output logic             o_done,
  output logic [OUT_W-1:0] o_period,
  output logic [NUM_W-1:0] o_remain,
  output logic             o_div_zero,
  output logic             o_overflow
);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  localparam int CNT_W = (NUM_W > 1) ? $clog2(NUM_W) : 1;
  localparam logic [NUM_W:0] ONE = 1;
  // Quotients at or above this are unrepresentable (all-ones is reserved)
  localparam logic [NUM_W:0] LIMIT = (ONE << OUT_W) - ONE;

  state_t           state;
  logic [NUM_W-1:0] num;
  logic [NUM_W-1:0] den;
  logic [NUM_W-1:0] rem;
  logic [CNT_W-1:0] cnt;
  logic             dz;

  logic [DEN_W+1:0] d_eff;
  logic [NUM_W-1:0] d_ext;
  logic [NUM_W:0]   trial;
  logic             take;
  logic [NUM_W-1:0] rem_nxt;
  logic             ovf;

  always_comb begin
    d_eff = (DEN_W+2)'(i_bpm_counter)
          * (DEN_W+2)'({1'b0, i_subdiv} + 3'd1);
    d_ext = NUM_W'(d_eff);
    trial = {rem, num[NUM_W-1]};
    take  = trial >= {1'b0, den};
    rem_nxt = take ? NUM_W'(trial - {1'b0, den})
                   : trial[NUM_W-1:0];
    ovf   = {1'b0, num} >= LIMIT;
  end

  assign o_busy = (state != IDLE);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      num        <= '0;
      den        <= '0;
      rem        <= '0;
      cnt        <= '0;
      dz         <= 1'b0;
      o_done     <= 1'b0;
      o_period   <= '0;
      o_remain   <= '0;
      o_div_zero <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            num   <= NUMERATOR;
            den   <= d_ext;
            rem   <= '0;
            cnt   <= CNT_W'(NUM_W - 1);
            dz    <= (d_ext == '0);
            state <= (d_ext == '0) ? DONE : DIV;
          end
        end
        DIV: begin
          rem <= rem_nxt;
          num <= {num[NUM_W-2:0], take};
          if (cnt == '0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          o_done <= 1'b1;
          state  <= IDLE;
          if (dz) begin
            o_period   <= '0;
            o_remain   <= '0;
            o_div_zero <= 1'b1;
            o_overflow <= 1'b0;
          end else if (ovf) begin
            o_period   <= '0;
            o_remain   <= rem;
            o_div_zero <= 1'b0;
            o_overflow <= 1'b1;
          end else begin
            o_period   <= num[OUT_W-1:0];
            o_remain   <= rem;
            o_div_zero <= 1'b0;
            o_overflow <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bpm_period_calc.sv
// Directed bench for bpm_period_calc: latency, quotient/remainder,
// zero-denominator, overflow, ignored restart and reset abort.
module tb_bpm_period_calc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [33:0] bpm = '0;
  logic [1:0]  subdiv = '0;

  logic        busy, done, dz, ovf;
  logic [33:0] period;
  logic [39:0] remain;

  logic        busy32, done32, dz32, ovf32;
  logic [31:0] period32;
  logic [39:0] remain32;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int snap;
  int n;

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  bpm_period_calc u_dut (
    .i_clk(clk), .i_reset(rst), .i_start(start),
    .i_bpm_counter(bpm), .i_subdiv(subdiv),
    .o_busy(busy), .o_done(done), .o_period(period),
    .o_remain(remain), .o_div_zero(dz), .o_overflow(ovf)
  );

  bpm_period_calc #(.OUT_W(32)) u_dut32 (
    .i_clk(clk), .i_reset(rst), .i_start(start),
    .i_bpm_counter(bpm), .i_subdiv(subdiv),
    .o_busy(busy32), .o_done(done32), .o_period(period32),
    .o_remain(remain32), .o_div_zero(dz32), .o_overflow(ovf32)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where o_done is seen.
  task automatic run(input logic [33:0] b, input logic [1:0] s,
                     input int exp_edges, input string tag);
    bpm = b;
    subdiv = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_edges"}, 64'(n), 64'(exp_edges));
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_period", 64'(period), 64'd0);
    chk("rst_remain", 64'(remain), 64'd0);
    chk("rst_dz", 64'(dz), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;

    run(34'd120, 2'd0, 41, "b120");
    chk("b120_period", 64'(period), 64'd100000000);
    chk("b120_remain", 64'(remain), 64'd0);
    chk("b120_dz", 64'(dz), 64'd0);
    chk("b120_ovf", 64'(ovf), 64'd0);
    repeat (5) @(negedge clk);
    chk("hold_period", 64'(period), 64'd100000000);
    chk("hold_done", 64'(done), 64'd0);

    run(34'd7, 2'd1, 41, "b7x2");
    chk("b7x2_period", 64'(period), 64'd857142857);
    chk("b7x2_remain", 64'(remain), 64'd2);

    // Back-to-back: started in the o_done cycle of the previous run
    run(34'd120, 2'd3, 41, "b120x4");
    chk("b120x4_period", 64'(period), 64'd25000000);
    chk("b120x4_remain", 64'(remain), 64'd0);

    run(34'd0, 2'd2, 1, "b0");
    chk("b0_period", 64'(period), 64'd0);
    chk("b0_remain", 64'(remain), 64'd0);
    chk("b0_dz", 64'(dz), 64'd1);
    chk("b0_ovf", 64'(ovf), 64'd0);

    run(34'd60, 2'd0, 41, "b60");
    chk("b60_period", 64'(period), 64'd200000000);
    chk("b60_dz", 64'(dz), 64'd0);

    run(34'd1, 2'd0, 41, "b1");
    chk("b1_period", 64'(period), 64'd12000000000);
    chk("b1_ovf", 64'(ovf), 64'd0);
    chk("b1w32_done", 64'(done32), 64'd1);
    chk("b1w32_period", 64'(period32), 64'd0);
    chk("b1w32_ovf", 64'(ovf32), 64'd1);
    chk("b1w32_dz", 64'(dz32), 64'd0);
    chk("b1w32_remain", 64'(remain32), 64'd0);

    // Restart request during DIV is ignored
    @(negedge clk);
    snap = done_cnt;
    bpm = 34'd120;
    subdiv = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    bpm = 34'd60;
    subdiv = 2'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 11;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ign_edges", 64'(n), 64'd41);
    chk("ign_period", 64'(period), 64'd100000000);
    repeat (50) @(negedge clk);
    chk("ign_pulses", 64'(done_cnt - snap), 64'd1);
    chk("ign_busy", 64'(busy), 64'd0);

    // Reset wins over start in the same cycle
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    chk("prio_busy", 64'(busy), 64'd0);
    chk("prio_period", 64'(period), 64'd0);

    // Reset mid-division aborts without a pulse
    run(34'd120, 2'd0, 41, "pre");
    snap = done_cnt;
    @(negedge clk);
    bpm = 34'd120;
    subdiv = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    chk("abort_busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_period", 64'(period), 64'd0);
    chk("abort_remain", 64'(remain), 64'd0);
    chk("abort_dz", 64'(dz), 64'd0);
    chk("abort_ovf", 64'(ovf), 64'd0);
    repeat (50) @(negedge clk);
    chk("abort_pulses", 64'(done_cnt - snap), 64'd1);
    chk("abort_hold", 64'(period), 64'd0);

    run(34'd240, 2'd0, 41, "b240");
    chk("b240_period", 64'(period), 64'd50000000);
    chk("b240_remain", 64'(remain), 64'd0);
    chk("b240w32_busy", 64'(busy32), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
